// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared defaults and FSM state encoding for the round-robin arbiters.
package rr_arb_pkg;
    localparam int DEF_N = 16;
    localparam int DEF_SW = 4;
    localparam int DEF_MAX_HOLD = 8;
    localparam logic IDLE = 1'b0;
    localparam logic GRANT = 1'b1;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational rotating-priority finder, first set req bit at or after ptr.
module rr_priority_pick
    import rr_arb_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int SW = DEF_SW
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] idx,
    output logic          any
);
    logic [2*N-1:0] scan;
    // Low half keeps only bits >= ptr; the upper copy supplies the wrapped-around bits.
    always_comb begin
        scan = {req, req & ~((N'(1) << ptr) - N'(1))};
        idx = '0;
        for (int i = 2*N-1; i >= 0; i--)
            if (scan[i]) idx = SW'(i % N);
    end
    assign any = |req;
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin owner of a shared N:1 mux select with hold limit and idle gap.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int SW = DEF_SW,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          done,
    output logic [SW-1:0] sel,
    output logic [N-1:0]  grant,
    output logic          valid,
    output logic          timeout
);
    logic          state;
    logic [SW-1:0] ptr;
    logic [SW-1:0] idx;
    logic          any;
    logic [7:0]    hold_cnt;
    logic          at_limit;
    logic          rel;

    rr_priority_pick #(.N(N), .SW(SW)) u_pick (
        .req(req),
        .ptr(ptr),
        .idx(idx),
        .any(any)
    );

    assign at_limit = hold_cnt == 8'(MAX_HOLD);
    assign rel = done | ~req[sel] | at_limit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel <= '0;
            grant <= '0;
            valid <= 1'b0;
            timeout <= 1'b0;
            ptr <= '0;
            hold_cnt <= '0;
        end else if (state == IDLE) begin
            timeout <= 1'b0;
            if (any) begin
                state <= GRANT;
                sel <= idx;
                grant <= N'(1) << idx;
                valid <= 1'b1;
                hold_cnt <= 8'd1;
            end
        end else if (rel) begin
            state <= IDLE;
            grant <= '0;
            valid <= 1'b0;
            ptr <= (sel == SW'(N-1)) ? '0 : sel + 1'b1;
            hold_cnt <= '0;
            // Only a pure hold-limit expiry counts as a forced release.
            timeout <= at_limit & ~done & req[sel];
        end else begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed checks of grant order, release, timeout and mux pairing.
module tb_rr_mux_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        valid;
    logic        timeout;
    logic [15:0] w;
    logic        f;
    int          n_tests = 0;
    int          n_fail = 0;

    rr_mux_arbiter dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .done(done),
        .sel(sel),
        .grant(grant),
        .valid(valid),
        .timeout(timeout)
    );

    assign f = w[sel];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; done = 1'b0; w = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_grant", 32'(grant), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_sel", 32'(sel), 0);
        check("rst_timeout", 32'(timeout), 0);
        // reset mid-grant to requester 5
        req = 16'h0020;
        step();
        check("g5_sel", 32'(sel), 5);
        check("g5_valid", 32'(valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_grant", 32'(grant), 0);
        check("midrst_valid", 32'(valid), 0);
        check("midrst_sel", 32'(sel), 0);
        check("midrst_timeout", 32'(timeout), 0);
        req = 16'hFFFF;
        step();
        check("first_sel", 32'(sel), 0);
        check("first_grant", 32'(grant), 32'h0001);
        req = '0;
        step();
        check("drop_valid", 32'(valid), 0);
        // single request, done on 3rd grant cycle
        req = 16'h0004;
        step();
        check("single_sel", 32'(sel), 2);
        check("single_grant", 32'(grant), 32'h0004);
        check("single_valid", 32'(valid), 1);
        step();
        step();
        check("single_hold3", 32'(valid), 1);
        done = 1'b1;
        step();
        done = 1'b0;
        check("single_rel_valid", 32'(valid), 0);
        check("single_rel_to", 32'(timeout), 0);
        // ptr=3: with bits 0 and 3 requesting, 3 must win
        req = 16'h0009;
        step();
        check("ptr3_sel", 32'(sel), 3);
        req = '0;
        step();
        // rotation and wrap from ptr 0
        do_reset();
        req = 16'hFFFF;
        for (int i = 0; i < 17; i++) begin
            step();
            check("rot_sel", 32'(sel), 32'(i % 16));
            check("rot_grant", 32'(grant), 32'(16'h1 << (i % 16)));
            done = 1'b1;
            step();
            done = 1'b0;
            check("rot_gap", 32'(valid), 0);
        end
        // timeout on requester 15
        req = 16'h8000;
        step();
        for (int i = 0; i < 8; i++) begin
            check("to_valid", 32'(valid), 1);
            check("to_sel", 32'(sel), 15);
            check("to_nopulse", 32'(timeout), 0);
            step();
        end
        check("to_rel_valid", 32'(valid), 0);
        check("to_pulse", 32'(timeout), 1);
        step();
        check("to_regrant_valid", 32'(valid), 1);
        check("to_regrant_sel", 32'(sel), 15);
        check("to_pulse_end", 32'(timeout), 0);
        req = '0;
        step();
        check("to_drop_to", 32'(timeout), 0);
        // done coinciding with hold limit is a normal release
        req = 16'h0100;
        step();
        for (int i = 0; i < 7; i++) step();
        check("lim_valid", 32'(valid), 1);
        done = 1'b1;
        step();
        done = 1'b0;
        check("lim_rel_valid", 32'(valid), 0);
        check("lim_no_to", 32'(timeout), 0);
        req = '0;
        step();
        // early drop and priority wrap: get ptr to 13 first
        req = 16'h1000;
        step();
        req = '0;
        step();
        req = 16'h2001;
        step();
        check("ed_sel13", 32'(sel), 13);
        req = 16'h0001;
        step();
        check("ed_rel_valid", 32'(valid), 0);
        check("ed_rel_to", 32'(timeout), 0);
        step();
        check("ed_sel0", 32'(sel), 0);
        check("ed_grant0", 32'(grant), 32'h0001);
        req = '0;
        step();
        // mux pairing
        w = 16'h2000;
        req = 16'h2000;
        step();
        check("mux_valid", 32'(valid), 1);
        check("mux_sel", 32'(sel), 13);
        check("mux_f1", 32'(f), 1);
        w = 16'h0004;
        #1;
        check("mux_f0", 32'(f), 0);
        req = '0;
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one 16:1 data mux (16-bit word in, 4-bit select, 1-bit out) among 16 requesters.
- Each requester owns one mux data input. The arbiter grants one requester at a time and drives the mux select with the granted index.
- It holds the grant until the owner releases it or a hold limit expires, then rotates priority.
- It sits directly in front of the mux select port. The mux itself is unchanged.

Parameters:
- N, 16, number of requesters (equals the mux input count).
- SW, 4, select width; must equal clog2(N).
- MAX_HOLD, 8, maximum consecutive grant cycles before forced release; range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i = requester i wants the mux.
- done  input  1  current owner releases the grant; sampled only in GRANT.
- sel  output  SW  mux select; registered; index of the current owner.
- grant  output  N  one-hot grant; registered; all-zero when idle.
- valid  output  1  high while a grant is active; the mux output is meaningful only when valid=1.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset: on a rising edge with rst=1, the block resets regardless of state:
  - state=IDLE, sel=0, grant=0, valid=0, timeout=0, ptr=0, hold_cnt=0.
  - A reset mid-grant drops the grant on the next edge. No release bookkeeping is done.
- State machine with two states, IDLE and GRANT.
- IDLE:
  - If req==0, stay in IDLE. Outputs: grant=0, valid=0, sel holds its last value.
  - Otherwise, winner = the first set bit of req scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - On that edge: sel=winner, grant=1<<winner, valid=1, hold_cnt=1, state goes to GRANT.
  - Latency: a req sampled at edge k with the arbiter idle gives grant visible after edge k (one cycle).
- GRANT, release condition: done=1, or req[sel]=0, or hold_cnt==MAX_HOLD.
  - On a release edge: grant=0, valid=0, ptr=(sel+1) mod N, hold_cnt=0, state goes to IDLE.
  - timeout=1 for exactly that cycle if and only if the release was caused only by hold_cnt==MAX_HOLD, with done=0 and req[sel]=1. Otherwise timeout=0.
  - Without a release: hold_cnt increments and sel/grant stay stable.
- Mandatory gap: at least one IDLE cycle separates consecutive grants, even back-to-back to different requesters. This gives the mux settling time.
- Fairness and wrap-around:
  - ptr wraps from N-1 to 0.
  - A requester that just released is lowest priority for the next arbitration.
  - With all 16 requesting continuously, grants go 0,1,…,15,0 in order.
- Simultaneous events:
  - done and hold-limit in the same cycle count as a normal release (timeout=0).
  - Changes to other req bits during GRANT are ignored until the next IDLE.
- Invariants:
  - grant is either all-zero or exactly one-hot.
  - When valid=1, grant[sel]=1.
  - hold_cnt never exceeds MAX_HOLD.
  - MAX_HOLD=1 gives a one-cycle grant every other cycle.

Decomposition:
- Shared package/include rr_arb_pkg holds:
  - default N, SW, MAX_HOLD;
  - state encoding (IDLE=1'b0, GRANT=1'b1).
- Sub-module rr_priority_pick: combinational rotating-priority finder.
  - Inputs: req[N-1:0], ptr[SW-1:0].
  - Outputs: idx[SW-1:0], any.
  - Implemented via a double-width masked scan; reused by future arbiters.
- Top level holds the FSM, ptr, hold_cnt and the output registers.

Test Plan:
1. Reset: assert rst during an active grant to requester 5 -> after the next edge, grant=0, valid=0, sel=0, timeout=0. The first grant after reset, with req=16'hFFFF, goes to index 0.
2. Single request: req=16'b0000_0000_0000_0100 held, done pulsed on the 3rd grant cycle -> sel=2, grant=16'h0004, valid=1 one cycle after req. Release on the done edge; ptr=3.
3. Rotation and wrap: req=16'hFFFF held, done pulsed every grant cycle -> grant order 0,1,2,…,15,0. Each grant is separated by exactly one valid=0 cycle.
4. Timeout: req=16'h8000 held, done=0, MAX_HOLD=8 -> sel=15, valid high for exactly 8 cycles, timeout pulse on the release cycle. Regrant to 15 after one idle cycle, with ptr having wrapped to 0.
5. Early drop and priority: grant to 13 (req=16'h2001, ptr=13); deassert req[13] -> release next edge, then grant to 0 (ptr=14 wraps past 14 and 15 to reach 0).
6. Mux pairing: connect the q3-style 16:1 mux with w=16'h2000 and req=16'h2000 -> during valid=1, sel=4'b1101 and f=1. With w=16'h0004, f=0.
